// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Shift layers are spread over the register stages lowest-first.
package shifter_pkg;

    typedef enum logic [2:0] {
        SHIFT_SLL = 3'd0,
        SHIFT_SRL = 3'd1,
        SHIFT_SRA = 3'd2,
        SHIFT_ROL = 3'd3,
        SHIFT_ROR = 3'd4
    } shift_op_t;

    function automatic int layers_per_stage(input int layers, input int stages);
        return (layers + stages - 1) / stages;
    endfunction

    function automatic int layer_stage(input int k, input int layers, input int stages);
        return k / layers_per_stage(layers, stages);
    endfunction

endpackage

// File: rtl/shifter_layer.sv
// One conditional shift/rotate by 2^K.
// The fill bit is only meaningful for non-rotating shifts.
module shifter_layer #(
    parameter int WIDTH = 32,
    parameter int K     = 0
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             left,
    input  logic             rotate,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);
    localparam int S = 1 << K;

    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;

    always_comb begin
        shl    = {data[WIDTH-S-1:0], (rotate ? data[WIDTH-1:WIDTH-S] : {S{fill}})};
        shr    = {(rotate ? data[S-1:0] : {S{fill}}), data[WIDTH-1:S]};
        result = !en ? data : (left ? shl : shr);
    end

endmodule

// File: rtl/shifter_pipelined.sv
// Pipelined barrel shifter with tag sideband, valid/ready backpressure and flush.
// Stage n registers the result of its own share of shift layers.
module shifter_pipelined
    import shifter_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int STAGES = 2,
    parameter  int TAG_W  = 5,
    localparam int LAYERS = $clog2(WIDTH),
    localparam int AMT_W  = LAYERS + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [AMT_W-1:0] i_amount,
    input  logic [2:0]       i_op,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [TAG_W-1:0] o_tag
);
    localparam int LPS = layers_per_stage(LAYERS, STAGES);

    logic [WIDTH-1:0]  data_q  [STAGES];
    logic [LAYERS-1:0] amt_q   [STAGES];
    shift_op_t         op_q    [STAGES];
    logic [TAG_W-1:0]  tag_q   [STAGES];
    logic [STAGES-1:0] sign_q;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] load;

    logic [WIDTH-1:0]  data_in  [STAGES];
    logic [LAYERS-1:0] amt_in   [STAGES];
    shift_op_t         op_in    [STAGES];
    logic [TAG_W-1:0]  tag_in   [STAGES];
    logic              sign_in  [STAGES];
    logic              valid_in [STAGES];
    logic              left     [STAGES];
    logic              rotate   [STAGES];
    logic              fill     [STAGES];
    logic [WIDTH-1:0]  data_out [STAGES];
    logic [WIDTH-1:0]  layer_out [LAYERS];

    shift_op_t op_norm;
    logic      big_amount;
    logic      take;

    always_comb begin
        op_norm    = (i_op > 3'd4) ? SHIFT_SLL : shift_op_t'(i_op);
        big_amount = i_amount[AMT_W-1];
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int FIRST = s * LPS;
        localparam int LAST  = (((s + 1) * LPS < LAYERS) ? (s + 1) * LPS : LAYERS) - 1;

        if (s == 0) begin : g_head
            // Out-of-range amounts: non-rotates saturate here, rotates just drop the MSB.
            assign data_in[s]  = (big_amount && op_norm != SHIFT_ROL && op_norm != SHIFT_ROR)
                               ? {WIDTH{op_norm == SHIFT_SRA && i_data[WIDTH-1]}} : i_data;
            assign amt_in[s]   = i_amount[LAYERS-1:0];
            assign op_in[s]    = op_norm;
            assign sign_in[s]  = i_data[WIDTH-1];
            assign tag_in[s]   = i_tag;
            assign valid_in[s] = i_valid;
        end else begin : g_link
            assign data_in[s]  = data_q[s-1];
            assign amt_in[s]   = amt_q[s-1];
            assign op_in[s]    = op_q[s-1];
            assign sign_in[s]  = sign_q[s-1];
            assign tag_in[s]   = tag_q[s-1];
            assign valid_in[s] = valid_q[s-1];
        end

        assign left[s]   = (op_in[s] == SHIFT_SLL) || (op_in[s] == SHIFT_ROL);
        assign rotate[s] = (op_in[s] == SHIFT_ROL) || (op_in[s] == SHIFT_ROR);
        assign fill[s]   = (op_in[s] == SHIFT_SRA) && sign_in[s];

        if (FIRST >= LAYERS) begin : g_pass
            assign data_out[s] = data_in[s];
        end else begin : g_layers
            assign data_out[s] = layer_out[LAST];
        end
    end

    for (genvar k = 0; k < LAYERS; k++) begin : g_layer
        localparam int S = layer_stage(k, LAYERS, STAGES);
        logic [WIDTH-1:0] layer_in;

        if (k % LPS == 0) begin : g_first
            assign layer_in = data_in[S];
        end else begin : g_chain
            assign layer_in = layer_out[k-1];
        end

        shifter_layer #(.WIDTH(WIDTH), .K(k)) u_layer (
            .data   (layer_in),
            .en     (amt_in[S][k]),
            .left   (left[S]),
            .rotate (rotate[S]),
            .fill   (fill[S]),
            .result (layer_out[k])
        );
    end

    // A stage may load when empty or when the stage after it is loading too.
    always_comb begin
        load = '0;
        take = i_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            load[s] = !valid_q[s] || take;
            take    = load[s];
        end
    end

    assign o_ready = load[0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            sign_q  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
                amt_q[s]  <= '0;
                op_q[s]   <= SHIFT_SLL;
                tag_q[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (load[s]) begin
                    valid_q[s] <= valid_in[s];
                    data_q[s]  <= data_out[s];
                    amt_q[s]   <= amt_in[s];
                    op_q[s]    <= op_in[s];
                    sign_q[s]  <= sign_in[s];
                    tag_q[s]   <= tag_in[s];
                end
            end
            if (i_flush) valid_q <= '0;
        end
    end

    assign o_valid = valid_q[STAGES-1];
    assign o_data  = data_q[STAGES-1];
    assign o_tag   = tag_q[STAGES-1];

endmodule

// File: tb/tb_shifter_pipelined.sv
// Self-checking bench: directed vector table, stall and flush sequences on a 2-stage
// instance, plus randomized scoreboard runs on 1-, 3- and 5-stage instances.
module tb_shifter_pipelined;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [5:0]  amt;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, beat_valid, shifter_ready, flush, result_valid, sink_ready;
    logic [31:0] operand, result;
    logic [5:0]  amount;
    logic [2:0]  op;
    logic [4:0]  tag, result_tag;

    shifter_pipelined #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (beat_valid),
        .o_ready  (shifter_ready),
        .i_data   (operand),
        .i_amount (amount),
        .i_op     (op),
        .i_tag    (tag),
        .i_flush  (flush),
        .o_valid  (result_valid),
        .i_ready  (sink_ready),
        .o_data   (result),
        .o_tag    (result_tag)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain shift/rotate arithmetic on the whole word.
    function automatic logic [31:0] golden(input logic [2:0] code, input logic [31:0] d, input int amt);
        logic [63:0] w;
        int r;
        r = amt % 32;
        case (code)
            3'd1: return (amt >= 32) ? 32'h0 : d >> amt;
            3'd2: return (amt >= 32) ? {32{d[31]}} : 32'($signed(d) >>> amt);
            3'd3: begin w = {d, d} << r; return w[63:32]; end
            3'd4: begin w = {d, d} >> r; return w[31:0]; end
            default: return (amt >= 32) ? 32'h0 : d << amt;
        endcase
    endfunction

    task automatic drive(input logic [2:0] o, input logic [31:0] d, input logic [5:0] a, input logic [4:0] t);
        op = o; operand = d; amount = a; tag = t;
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int STG = (g == 0) ? 1 : (g == 1) ? 3 : 5;
        logic        r_rst, r_valid, r_oready, r_flush, r_ovalid, r_ready;
        logic [31:0] r_data, r_odata;
        logic [5:0]  r_amt;
        logic [2:0]  r_op;
        logic [4:0]  r_tag, r_otag;
        logic        done = 1'b0;

        shifter_pipelined #(.WIDTH(32), .STAGES(STG), .TAG_W(5)) u_dut (
            .i_clk    (clk),
            .i_rst    (r_rst),
            .i_valid  (r_valid),
            .o_ready  (r_oready),
            .i_data   (r_data),
            .i_amount (r_amt),
            .i_op     (r_op),
            .i_tag    (r_tag),
            .i_flush  (r_flush),
            .o_valid  (r_ovalid),
            .i_ready  (r_ready),
            .o_data   (r_odata),
            .o_tag    (r_otag)
        );

        initial begin
            logic [36:0] q[$];
            r_rst = 1'b1; r_valid = 1'b0; r_flush = 1'b0; r_ready = 1'b0;
            r_data = '0; r_amt = '0; r_op = '0; r_tag = '0;
            repeat (3) @(posedge clk);
            #1 r_rst = 1'b0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                @(posedge clk); #1;
                r_rst   = (cyc == 300);
                r_valid = ($urandom_range(0, 3) != 0);
                r_ready = ($urandom_range(0, 3) != 0);
                r_op    = 3'($urandom_range(0, 7));
                r_amt   = 6'($urandom_range(0, 63));
                r_data  = $urandom;
                r_tag   = 5'($urandom);
                @(negedge clk);
                if (cyc == 301) begin
                    check($sformatf("rst_ovalid_s%0d", STG), 64'(r_ovalid), 64'd0);
                    check($sformatf("rst_odata_s%0d", STG), 64'(r_odata), 64'd0);
                end
                if (r_rst) begin
                    q.delete();
                end else begin
                    check($sformatf("rand_ready_s%0d", STG), 64'(r_oready),
                          64'((q.size() < STG) || r_ready));
                    if (r_ovalid) begin
                        if (q.size() == 0) begin
                            check($sformatf("rand_spurious_s%0d", STG), 64'd1, 64'd0);
                        end else begin
                            check($sformatf("rand_data_s%0d", STG), 64'(r_odata), 64'(q[0][31:0]));
                            check($sformatf("rand_tag_s%0d", STG), 64'(r_otag), 64'(q[0][36:32]));
                            if (r_ready) void'(q.pop_front());
                        end
                    end
                    if (r_valid && r_oready)
                        q.push_back({r_tag, golden(r_op, r_data, int'(r_amt))});
                end
            end
            @(posedge clk); #1;
            r_rst = 1'b0; r_valid = 1'b0; r_ready = 1'b1;
            for (int cyc = 0; cyc < 40 && q.size() > 0; cyc++) begin
                @(negedge clk);
                if (r_ovalid) begin
                    check($sformatf("drain_data_s%0d", STG), 64'(r_odata), 64'(q[0][31:0]));
                    check($sformatf("drain_tag_s%0d", STG), 64'(r_otag), 64'(q[0][36:32]));
                    void'(q.pop_front());
                end
                @(posedge clk); #1;
            end
            check($sformatf("drain_left_s%0d", STG), 64'(q.size()), 64'd0);
            done = 1'b1;
        end
    end

    initial begin
        vec_t vecs[15];
        logic [36:0] dq[$];
        logic [2:0]  b_op[8];
        logic [31:0] b_data[8];
        logic [5:0]  b_amt[8];
        int sent, got;
        logic all_done;

        vecs[0]  = '{3'd0, 32'h0A0A0A0A, 6'd4,  5'd7,  32'hA0A0A0A0};
        vecs[1]  = '{3'd1, 32'hFA0A0A0A, 6'd4,  5'd1,  32'h0FA0A0A0};
        vecs[2]  = '{3'd2, 32'hFA0A0A0A, 6'd4,  5'd2,  32'hFFA0A0A0};
        vecs[3]  = '{3'd2, 32'h80000000, 6'd32, 5'd3,  32'hFFFFFFFF};
        vecs[4]  = '{3'd1, 32'h80000000, 6'd32, 5'd4,  32'h00000000};
        vecs[5]  = '{3'd4, 32'h00000001, 6'd1,  5'd5,  32'h80000000};
        vecs[6]  = '{3'd3, 32'h80000000, 6'd33, 5'd6,  32'h00000001};
        vecs[7]  = '{3'd3, 32'hAA55AA55, 6'd0,  5'd8,  32'hAA55AA55};
        vecs[8]  = '{3'd6, 32'h00000001, 6'd3,  5'd9,  32'h00000008};
        vecs[9]  = '{3'd0, 32'h00000001, 6'd31, 5'd10, 32'h80000000};
        vecs[10] = '{3'd2, 32'h7FFFFFFF, 6'd63, 5'd11, 32'h00000000};
        vecs[11] = '{3'd4, 32'h12345678, 6'd36, 5'd12, 32'h81234567};
        vecs[12] = '{3'd2, 32'h80000001, 6'd0,  5'd13, 32'h80000001};
        vecs[13] = '{3'd0, 32'hFFFFFFFF, 6'd40, 5'd14, 32'h00000000};
        vecs[14] = '{3'd4, 32'h000000F0, 6'd63, 5'd31, 32'h000001E0};

        rst = 1'b1; beat_valid = 1'b0; flush = 1'b0; sink_ready = 1'b0;
        drive(3'd0, 32'h0, 6'd0, 5'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ovalid", 64'(result_valid), 64'd0);
        check("reset_odata", 64'(result), 64'd0);
        check("reset_otag", 64'(result_tag), 64'd0);
        check("reset_oready", 64'(shifter_ready), 64'd1);

        // Directed table: one op at a time, latency of exactly two cycles.
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i].op, vecs[i].data, vecs[i].amt, vecs[i].tag);
            beat_valid = 1'b1; sink_ready = 1'b1;
            @(negedge clk);
            check($sformatf("vec%0d_accept", i), 64'(shifter_ready), 64'd1);
            @(posedge clk); #1 beat_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_early", i), 64'(result_valid), 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 64'(result_valid), 64'd1);
            check($sformatf("vec%0d_data", i), 64'(result), 64'(vecs[i].exp));
            check($sformatf("vec%0d_tag", i), 64'(result_tag), 64'(vecs[i].tag));
        end

        // Eight back-to-back beats with the sink stalled in cycles 3..6.
        for (int k = 0; k < 8; k++) begin
            b_op[k] = 3'(k % 5); b_data[k] = $urandom; b_amt[k] = 6'(k * 5);
        end
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(posedge clk); #1;
            sink_ready = !(cyc >= 3 && cyc <= 6);
            beat_valid = (sent < 8);
            if (sent < 8) drive(b_op[sent], b_data[sent], b_amt[sent], 5'(sent));
            @(negedge clk);
            check("stream_ready", 64'(shifter_ready), 64'((dq.size() < 2) || sink_ready));
            if (result_valid) begin
                if (dq.size() == 0) begin
                    check("stream_spurious", 64'd1, 64'd0);
                end else begin
                    check("stream_data", 64'(result), 64'(dq[0][31:0]));
                    check("stream_tag", 64'(result_tag), 64'(dq[0][36:32]));
                    if (sink_ready) begin void'(dq.pop_front()); got++; end
                end
            end
            if (beat_valid && shifter_ready) begin
                dq.push_back({5'(sent), golden(b_op[sent], b_data[sent], int'(b_amt[sent]))});
                sent++;
            end
        end
        check("stream_count", 64'(got), 64'd8);

        // Flush with two ops in flight and a new beat presented in the flush cycle.
        @(posedge clk); #1;
        beat_valid = 1'b0; sink_ready = 1'b0;
        @(posedge clk); #1;
        beat_valid = 1'b1; drive(3'd0, 32'h11111111, 6'd1, 5'd21);
        @(posedge clk); #1;
        drive(3'd0, 32'h22222222, 6'd1, 5'd22);
        @(posedge clk); #1;
        drive(3'd0, 32'h33333333, 6'd1, 5'd23); flush = 1'b1;
        @(negedge clk);
        check("flush_full", 64'(result_valid), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; sink_ready = 1'b1;
        drive(3'd1, 32'hF0F0F0F0, 6'd4, 5'd24);
        @(negedge clk);
        check("flush_ovalid", 64'(result_valid), 64'd0);
        check("flush_ready", 64'(shifter_ready), 64'd1);
        @(posedge clk); #1 beat_valid = 1'b0;
        @(negedge clk);
        check("flush_gap", 64'(result_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("flush_next_valid", 64'(result_valid), 64'd1);
        check("flush_next_data", 64'(result), 64'(32'h0F0F0F0F));
        check("flush_next_tag", 64'(result_tag), 64'd24);
        @(posedge clk); #1;
        @(negedge clk);
        check("flush_after", 64'(result_valid), 64'd0);

        fork
            wait (g_rand[0].done && g_rand[1].done && g_rand[2].done);
            #200000;
        join_any
        disable fork;
        all_done = g_rand[0].done && g_rand[1].done && g_rand[2].done;
        check("rand_complete", 64'(all_done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
